// File: rtl/fu_issuer_pkg.sv
// -----------------------------------------------------------------------------
// fu_issuer_pkg
// Shared definitions for the functional-unit issuer:
//   - default operand/result width and opcode width
//   - default result latency and width of the latency counter
//   - NOP opcode value driven to the fu while no command is in flight
//   - FSM state encoding
// -----------------------------------------------------------------------------
package fu_issuer_pkg;

    localparam int DSIZE_DEF  = 16;
    localparam int OPSIZE_DEF = 5;
    localparam int LAT_DEF    = 1;
    localparam int CNT_W      = 4;   // holds LAT in 1..15
    localparam int NOP_OP     = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : fu_issuer_pkg

// File: rtl/fu_issuer.sv
// -----------------------------------------------------------------------------
// fu_issuer
// Issues one command at a time to a fixed-latency functional unit (fu), waits
// LAT cycles, captures the fu result and holds it until the consumer takes it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command channel
//   cmd_a, cmd_b, cmd_op    command operands and opcode
//   fu_a, fu_b, fu_op       operands/opcode driven to the fu
//   fu_f                    fu result
//   res_valid/res_ready     result channel
//   res_data, res_op        captured result and the opcode that produced it
//   res_cnt                 count of consumed results (wraps 255 -> 0)
//   o_dbg_state             current FSM state, for observation only
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. The source holds its payload while valid
// is high and ready is low; ready may be low indefinitely. Here cmd_ready is
// high only in IDLE and res_valid is high only in DONE.
// -----------------------------------------------------------------------------
module fu_issuer
    import fu_issuer_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int OPSIZE = OPSIZE_DEF,
    parameter int LAT    = LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DSIZE-1:0]  cmd_a,
    input  logic [DSIZE-1:0]  cmd_b,
    input  logic [OPSIZE-1:0] cmd_op,
    output logic [DSIZE-1:0]  fu_a,
    output logic [DSIZE-1:0]  fu_b,
    output logic [OPSIZE-1:0] fu_op,
    input  logic [DSIZE-1:0]  fu_f,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DSIZE-1:0]  res_data,
    output logic [OPSIZE-1:0] res_op,
    output logic [7:0]        res_cnt,
    output logic [1:0]        o_dbg_state
);

    state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic [DSIZE-1:0]   r_fu_a,      w_fu_a_nxt;
    logic [DSIZE-1:0]   r_fu_b,      w_fu_b_nxt;
    logic [OPSIZE-1:0]  r_fu_op,     w_fu_op_nxt;
    logic               r_res_valid, w_res_valid_nxt;
    logic [DSIZE-1:0]   r_res_data,  w_res_data_nxt;
    logic [OPSIZE-1:0]  r_res_op,    w_res_op_nxt;
    logic [7:0]         r_res_cnt,   w_res_cnt_nxt;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_fu_a      <= '0;
            r_fu_b      <= '0;
            r_fu_op     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
            r_res_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fu_a      <= w_fu_a_nxt;
            r_fu_b      <= w_fu_b_nxt;
            r_fu_op     <= w_fu_op_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_op    <= w_res_op_nxt;
            r_res_cnt   <= w_res_cnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_fu_a_nxt      = r_fu_a;
        w_fu_b_nxt      = r_fu_b;
        w_fu_op_nxt     = r_fu_op;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_op_nxt    = r_res_op;
        w_res_cnt_nxt   = r_res_cnt;

        case (r_state)
            ST_IDLE: begin
                // cmd_ready is high in IDLE, so cmd_valid alone is a handshake.
                if (cmd_valid) begin
                    w_fu_a_nxt  = cmd_a;
                    w_fu_b_nxt  = cmd_b;
                    w_fu_op_nxt = cmd_op;
                    w_res_op_nxt = cmd_op;
                    w_cnt_nxt   = CNT_W'(LAT);
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter is loaded with LAT and sampled at zero, so the
                // capture edge lands LAT+1 edges after the handshake.
                if (r_cnt == '0) begin
                    w_res_data_nxt  = fu_f;
                    w_res_valid_nxt = 1'b1;
                    w_fu_op_nxt     = OPSIZE'(NOP_OP);
                    w_state_nxt     = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_res_cnt_nxt   = r_res_cnt + 8'd1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // cmd_ready is a pure decode of the state flop, so it is glitch-free and
    // already high on the first edge after reset release.
    assign cmd_ready   = (r_state == ST_IDLE);
    assign fu_a        = r_fu_a;
    assign fu_b        = r_fu_b;
    assign fu_op       = r_fu_op;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_op      = r_res_op;
    assign res_cnt     = r_res_cnt;
    assign o_dbg_state = r_state;

endmodule : fu_issuer

// File: tb/tb_fu_issuer.sv
// -----------------------------------------------------------------------------
// tb_fu_issuer
// Directed bench for fu_issuer. Two instances share clock and reset:
//   u_dut  : LAT=1  (main function, backpressure, back-to-back, reset, wrap)
//   u_lat15: LAT=15 (long latency result timing)
// Each fu is modelled as f = a + b.
// -----------------------------------------------------------------------------
module tb_fu_issuer;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- LAT=1 instance ----------------
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [4:0]  cmd_op;
    logic [15:0] fu_a, fu_b, fu_f;
    logic [4:0]  fu_op;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [4:0]  res_op;
    logic [7:0]  res_cnt;
    logic [1:0]  dbg_state;

    assign fu_f = fu_a + fu_b;

    fu_issuer #(.DSIZE(16), .OPSIZE(5), .LAT(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_op      (fu_op),
        .fu_f       (fu_f),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_cnt    (res_cnt),
        .o_dbg_state(dbg_state)
    );

    // ---------------- LAT=15 instance ----------------
    logic        l_cmd_valid, l_cmd_ready;
    logic [15:0] l_cmd_a, l_cmd_b;
    logic [4:0]  l_cmd_op;
    logic [15:0] l_fu_a, l_fu_b, l_fu_f;
    logic [4:0]  l_fu_op;
    logic        l_res_valid, l_res_ready;
    logic [15:0] l_res_data;
    logic [4:0]  l_res_op;
    logic [7:0]  l_res_cnt;
    logic [1:0]  l_dbg_state;

    assign l_fu_f = l_fu_a + l_fu_b;

    fu_issuer #(.DSIZE(16), .OPSIZE(5), .LAT(15)) u_lat15 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (l_cmd_valid),
        .cmd_ready  (l_cmd_ready),
        .cmd_a      (l_cmd_a),
        .cmd_b      (l_cmd_b),
        .cmd_op     (l_cmd_op),
        .fu_a       (l_fu_a),
        .fu_b       (l_fu_b),
        .fu_op      (l_fu_op),
        .fu_f       (l_fu_f),
        .res_valid  (l_res_valid),
        .res_ready  (l_res_ready),
        .res_data   (l_res_data),
        .res_op     (l_res_op),
        .res_cnt    (l_res_cnt),
        .o_dbg_state(l_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          compared;
    int          mismatched;
    logic [15:0] exp_q[$];
    logic [4:0]  exp_op_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s check", tag);
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [4:0]  vo [3];
    logic        rdy;
    logic        seen;
    int          hs;
    int          found;
    logic [15:0] e_data;
    logic [4:0]  e_op;

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_op      = '0;
        res_ready   = 1'b0;
        l_cmd_valid = 1'b0;
        l_cmd_a     = '0;
        l_cmd_b     = '0;
        l_cmd_op    = '0;
        l_res_ready = 1'b0;

        // ---- reset: outputs zero while held ----
        #3;
        check("rst_fu_a",      fu_a,      16'h0);
        check("rst_fu_b",      fu_b,      16'h0);
        check("rst_fu_op",     fu_op,     5'h0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data",  res_data,  16'h0);
        check("rst_res_op",    res_op,    5'h0);
        check("rst_res_cnt",   res_cnt,   8'h0);
        check("rst_l_res_cnt", l_res_cnt, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_state",     dbg_state, 2'd0);

        // ---- single command: 1 + 1, op 00100 ----
        cmd_valid = 1'b1;
        cmd_a     = 16'h0001;
        cmd_b     = 16'h0001;
        cmd_op    = 5'b00100;
        res_ready = 1'b0;
        @(posedge clk); #1;                 // edge T: handshake
        cmd_valid = 1'b0;
        check("one_fu_op_t1",  fu_op,     5'b00100);
        check("one_fu_a",      fu_a,      16'h0001);
        check("one_fu_b",      fu_b,      16'h0001);
        check("one_cmd_ready", cmd_ready, 1'b0);
        check("one_valid_t1",  res_valid, 1'b0);
        @(posedge clk); #1;                 // T+1
        check("one_fu_op_t2",  fu_op,     5'b00100);
        check("one_valid_t2",  res_valid, 1'b0);
        @(posedge clk); #1;                 // T+2: capture
        check("one_valid_t3",  res_valid, 1'b1);
        check("one_data",      res_data,  16'h0002);
        check("one_res_op",    res_op,    5'b00100);
        check("one_fu_op_nop", fu_op,     5'h0);
        check("one_fu_a_kept", fu_a,      16'h0001);
        check("one_state",     dbg_state, 2'd2);

        // ---- backpressure: 5 cycles with res_ready low, foreign cmd offered ----
        cmd_valid = 1'b1;
        cmd_a     = 16'h00AA;
        cmd_b     = 16'h0055;
        cmd_op    = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid",     res_valid, 1'b1);
            check("bp_data",      res_data,  16'h0002);
            check("bp_cmd_ready", cmd_ready, 1'b0);
        end
        check("bp_fu_a_kept", fu_a,  16'h0001);
        check("bp_fu_op_nop", fu_op, 5'h0);
        check("bp_res_op",    res_op, 5'b00100);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("pop_valid",     res_valid, 1'b0);
        check("pop_cnt",       res_cnt,   8'd1);
        check("pop_cmd_ready", cmd_ready, 1'b1);
        // res_ready while idle does nothing
        @(posedge clk); #1;
        check("idle_ready_cnt",   res_cnt,   8'd1);
        check("idle_ready_state", dbg_state, 2'd0);

        // ---- back-to-back: three commands, cmd_valid held, res_ready high ----
        va[0] = 16'h0003; vb[0] = 16'h0004; vo[0] = 5'h01;
        va[1] = 16'hFFFF; vb[1] = 16'h0002; vo[1] = 5'h00;
        va[2] = 16'h1234; vb[2] = 16'h1111; vo[2] = 5'h15;
        hs        = 0;
        cmd_a     = va[0];
        cmd_b     = vb[0];
        cmd_op    = vo[0];
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy && cmd_valid) begin
                check("b2b_hs_cycle", cyc, hs * 4);
                exp_q.push_back(cmd_a + cmd_b);
                exp_op_q.push_back(cmd_op);
                hs++;
                if (hs < 3) begin
                    cmd_a  = va[hs];
                    cmd_b  = vb[hs];
                    cmd_op = vo[hs];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_result", 1'b1, 1'b0);
                end else begin
                    e_data = exp_q.pop_front();
                    e_op   = exp_op_q.pop_front();
                    check("b2b_data", res_data, e_data);
                    check("b2b_op",   res_op,   e_op);
                end
            end
        end
        cmd_valid = 1'b0;
        check("b2b_hs_count",  hs,           3);
        check("b2b_cnt",       res_cnt,      8'd4);
        check("b2b_drained",   exp_q.size(), 0);

        // ---- reset one cycle after handshake ----
        res_ready = 1'b0;
        cmd_a     = 16'h0005;
        cmd_b     = 16'h0006;
        cmd_op    = 5'h09;
        cmd_valid = 1'b1;
        @(posedge clk); #1;                 // handshake
        cmd_valid = 1'b0;
        check("mid_fu_op", fu_op, 5'h09);
        @(posedge clk); #1;                 // in WAIT
        rst_n = 1'b0;
        #1;
        check("mid_rst_fu_op",     fu_op,     5'h0);
        check("mid_rst_fu_a",      fu_a,      16'h0);
        check("mid_rst_valid",     res_valid, 1'b0);
        check("mid_rst_cnt",       res_cnt,   8'd0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        check("mid_no_result", seen,    1'b0);
        check("mid_cnt_after", res_cnt, 8'd0);
        check("mid_fu_op_after", fu_op, 5'h0);

        // ---- wrap: 256 completions at 4 cycles each ----
        cmd_a     = 16'h0010;
        cmd_b     = 16'h0020;
        cmd_op    = 5'h03;
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        repeat (1020) @(posedge clk);
        #1;
        check("wrap_cnt_255", res_cnt, 8'hFF);
        repeat (4) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("wrap_cnt_0",     res_cnt,   8'h00);
        check("wrap_cmd_ready", cmd_ready, 1'b1);

        // ---- LAT=15: result lands 16 edges after handshake ----
        l_cmd_a     = 16'h0100;
        l_cmd_b     = 16'h0023;
        l_cmd_op    = 5'h0A;
        l_res_ready = 1'b0;
        l_cmd_valid = 1'b1;
        @(posedge clk); #1;                 // edge T
        l_cmd_valid = 1'b0;
        found = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 15) begin
                check("l15_fu_op_k15",  l_fu_op,     5'h0A);
                check("l15_valid_k15",  l_res_valid, 1'b0);
                check("l15_cmd_ready",  l_cmd_ready, 1'b0);
            end
            if (l_res_valid && found == 0) found = k;
        end
        check("l15_latency",  found,       16);
        check("l15_data",     l_res_data,  16'h0123);
        check("l15_op",       l_res_op,    5'h0A);
        check("l15_state",    l_dbg_state, 2'd2);
        l_res_ready = 1'b1;
        @(posedge clk); #1;
        l_res_ready = 1'b0;
        check("l15_cnt",      l_res_cnt,   8'd1);
        check("l15_valid_clr", l_res_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fu_issuer

// File: doc/fu_issuer.md
FU_ISSUER -- requirements
Module: fu_issuer

Interface
REQ-001 Parameter DSIZE, default 16, operand/result width SHALL match fu.
REQ-002 Parameter OPSIZE, default 5, opcode width SHALL match fu.
REQ-003 Parameter LAT, default 1, range 1..15, fu result latency in cycles SHALL be configurable.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  issuer can accept a command.
REQ-008 cmd_a, cmd_b  input  DSIZE each  operands.
REQ-009 cmd_op  input  OPSIZE  opcode.
REQ-010 fu_a, fu_b  output  DSIZE each  operands driven to fu data_a/data_b.
REQ-011 fu_op  output  OPSIZE  opcode driven to fu op.
REQ-012 fu_f  input  DSIZE  fu result f.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  result consumed.
REQ-015 res_data  output  DSIZE  captured result; res_op  output  OPSIZE  opcode tag of that result.
REQ-016 res_cnt  output  8  completed-result counter.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, DONE; all outputs registered.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a handshake occurs on an edge with cmd_valid=1 and cmd_ready=1.
REQ-019 On handshake at edge T: fu_a/fu_b/fu_op/res_op SHALL load cmd_a/cmd_b/cmd_op/cmd_op, wait counter SHALL load LAT, state SHALL go WAIT.
REQ-020 In WAIT, counter SHALL decrement each cycle; fu_a/fu_b/fu_op SHALL stay stable.
REQ-021 In WAIT with counter 0, next edge (T+LAT+1) SHALL capture fu_f into res_data, set res_valid=1, set fu_op=0 (NOP), go DONE.
REQ-022 In DONE, res_valid and res_data SHALL hold until res_ready=1; on that edge res_valid SHALL clear, res_cnt SHALL increment (wrap 255->0), state SHALL go IDLE.
REQ-023 Throughput: one command per LAT+3 cycles maximum; one bubble cycle in IDLE after each result.
REQ-024 cmd_valid outside IDLE SHALL be ignored; command inputs SHALL not be sampled.
REQ-025 res_ready without res_valid SHALL have no effect.
REQ-026 fu_a/fu_b SHALL retain last operands after capture; only fu_op returns to 0.
REQ-027 Opcode values SHALL pass through unchecked, including 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, counter 0, fu_a/fu_b/fu_op 0, res_valid 0, res_data 0, res_op 0, res_cnt 0.
REQ-029 Reset mid-operation (WAIT or DONE) SHALL discard the in-flight command and its result without incrementing res_cnt.
REQ-030 After rst_n rises, cmd_ready SHALL be 1 from the first edge.

Structure
REQ-031 Shared package SHALL hold DSIZE/OPSIZE defaults, NOP opcode constant (0), FSM state encoding.
REQ-032 Single module; no sub-module; latency counter 4 bits inline.

Verification
REQ-033 Reset: rst_n=0 for half cycle -> all outputs 0, cmd_ready=1 after release.
REQ-034 Single command: cmd_a=16'h0001, cmd_b=16'h0001, cmd_op=5'b00100, LAT=1, fu model f=a+b -> fu_op=5'b00100 for 2 cycles, res_valid at T+2, res_data=16'h0002, res_op=5'b00100, res_cnt=1.
REQ-035 Backpressure: res_ready held 0 for 5 cycles -> res_valid/res_data stable, cmd_ready=0, a second cmd_valid ignored.
REQ-036 Back-to-back: 3 commands with cmd_valid held high, res_ready=1 -> handshakes every LAT+3 cycles, res_cnt=3.
REQ-037 Reset mid-WAIT: rst_n pulse one cycle after handshake -> res_valid never asserts, res_cnt=0, fu_op=0.
REQ-038 Wrap: 256 completed commands -> res_cnt=0; LAT=15 -> result at T+16.
